// File: rtl/dr_req_arbiter.sv
// dr_req_arbiter: round-robin merge of NPORTS L2 request channels into one directory-bank request channel.
// Optional build macro DR_REQ_ARB_STATS_EN adds saturating per-port grant counters and a stall counter.
package dr_req_arbiter_pkg;
    typedef struct packed {
        logic [4:0]  nid;
        logic [5:0]  l2id;
        logic [2:0]  cmd;
        logic [49:0] paddr;
    } I_l2todr_req_type;
endpackage

module dr_req_arbiter
    import dr_req_arbiter_pkg::*;
#(
    parameter int NPORTS = 4,
    parameter int PW     = $clog2(NPORTS)
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [NPORTS-1:0]                          in_valid,
    output logic [NPORTS-1:0]                          in_retry,
    input  logic [NPORTS*$bits(I_l2todr_req_type)-1:0] in_req,
    output logic                                       out_valid,
    input  logic                                       out_retry,
    output I_l2todr_req_type                           out_req,
    output logic [PW-1:0]                              out_port
`ifdef DR_REQ_ARB_STATS_EN
    ,
    output logic [NPORTS*16-1:0]                       stat_grant_cnt,
    output logic [15:0]                                stat_stall_cnt
`endif
);
    localparam int RW = $bits(I_l2todr_req_type);

    logic [NPORTS-1:0] r_buf_v;
    I_l2todr_req_type  r_buf_d [NPORTS];
    logic              r_out_valid;
    I_l2todr_req_type  r_out_req;
    logic [PW-1:0]     r_out_port;
    logic [PW-1:0]     r_last_grant;

    logic              w_out_free;
    logic [NPORTS-1:0] w_grant;
    logic [NPORTS-1:0] w_acc;
    logic              w_found;
    logic [PW-1:0]     w_gidx;

    assign w_out_free = ~r_out_valid | ~out_retry;
    assign in_retry   = r_buf_v & ~w_grant;
    assign w_acc      = in_valid & ~in_retry;

    // Arbitration: scan from the port after the last winner, wrapping at NPORTS-1.
    always_comb begin
        logic [PW:0] idx;
        w_grant = '0;
        w_found = 1'b0;
        w_gidx  = '0;
        idx     = '0;
        if (w_out_free) begin
            for (int k = 1; k <= NPORTS; k++) begin
                idx = {1'b0, r_last_grant} + (PW+1)'(k);
                if (idx >= (PW+1)'(NPORTS)) idx = idx - (PW+1)'(NPORTS);
                if (!w_found && r_buf_v[idx[PW-1:0]]) begin
                    w_found                 = 1'b1;
                    w_gidx                  = idx[PW-1:0];
                    w_grant[idx[PW-1:0]]    = 1'b1;
                end
            end
        end
    end

    // Input buffer stage: a granted entry may be refilled on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf_v <= '0;
        end else begin
            r_buf_v <= (r_buf_v & ~w_grant) | w_acc;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NPORTS; i++) begin
            if (w_acc[i]) r_buf_d[i] <= in_req[i*RW +: RW];
        end
    end

    // Output stage: holds while the bank retries; last_grant moves only with a grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out_req    <= '0;
            r_out_port   <= '0;
            r_last_grant <= PW'(NPORTS-1);
        end else if (w_out_free) begin
            r_out_valid <= w_found;
            if (w_found) begin
                r_out_req    <= r_buf_d[w_gidx];
                r_out_port   <= w_gidx;
                r_last_grant <= w_gidx;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_req   = r_out_req;
    assign out_port  = r_out_port;

`ifdef DR_REQ_ARB_STATS_EN
    logic [15:0] r_grant_cnt [NPORTS];
    logic [15:0] r_stall_cnt;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NPORTS; i++) r_grant_cnt[i] <= '0;
            r_stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NPORTS; i++) begin
                if (w_grant[i]) r_grant_cnt[i] <= sat_inc(r_grant_cnt[i]);
            end
            if (r_out_valid && out_retry) r_stall_cnt <= sat_inc(r_stall_cnt);
        end
    end

    always_comb begin
        stat_grant_cnt = '0;
        for (int i = 0; i < NPORTS; i++) stat_grant_cnt[i*16 +: 16] = r_grant_cnt[i];
    end

    assign stat_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: doc/dr_req_arbiter.md
Name: dr_req_arbiter

Overview:
Round-robin arbiter that merges NPORTS independent L2 request channels into the single l2todr_req channel of one directory bank.
- Sits between the per-node L2 request links and the directory bank.
- Uses the standard valid/retry handshake on every side: a transfer occurs when valid=1 and retry=0 on the same clk edge.
- Provides one buffered entry per input and a registered output stage, so the bank sees a clean, stable request stream.

Parameters:
NPORTS, 4, number of L2 request inputs (2..8)
PW, $clog2(NPORTS), width of the port index

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  NPORTS  per-port request valid
in_retry  out  NPORTS  per-port back-pressure
in_req  in  NPORTS*$bits(I_l2todr_req_type)  per-port request {nid,l2id,cmd,paddr}; port i occupies slice i
out_valid  out  1  request valid to the directory bank
out_retry  in  1  directory bank back-pressure
out_req  out  $bits(I_l2todr_req_type)  granted request
out_port  out  PW  input index the current out_req came from

Behaviour:
- Interface decision: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: all buffer valids=0, out_valid=0, out_req=0, out_port=0, last_grant=NPORTS-1 (so port 0 has first priority). in_retry is combinational and therefore reads 0 after reset.
- Per-input buffer (1 entry, buf_v[i], buf_d[i]):
  - loads in_req slice i on the edge where in_valid[i] & ~in_retry[i];
  - in_retry[i] = buf_v[i] & ~grant[i];
  - same-cycle free-and-refill is allowed, giving full per-port throughput.
- Output stage (1 entry): out_free = ~out_valid | ~out_retry.
- Arbitration (combinational, each cycle):
  - when out_free, scan buf_v starting at (last_grant+1) mod NPORTS, wrapping at NPORTS-1 back to 0;
  - first set bit wins; grant is one-hot or zero.
- On a grant to port g, at the clk edge:
  - out_req <= buf_d[g], out_port <= g, out_valid <= 1;
  - buf_v[g] <= 0, unless refilled the same cycle;
  - last_grant <= g.
- No grant while out_free=1: out_valid <= 0.
- Hold rule: while out_valid & out_retry, out_req, out_port and out_valid are stable, no grant is issued, and last_grant is frozen.
- Latency: input handshake at edge N -> buffered -> out_valid at edge N+1 at the earliest (1 cycle of buffer plus 1 registered output).
- Throughput: 1 request/cycle aggregate with out_retry=0.
- Fairness: with K ports continuously pending, each port is granted exactly once per K grants. Worst-case wait is NPORTS-1 grants.
- Ordering: requests from the same port leave in arrival order. No ordering is guaranteed across ports.
- Single requester: granted back-to-back every cycle; the pointer simply stays on it.
- Reset asserted mid-operation: all buffered and output requests are dropped with no handshake. Senders must resend.
- in_valid with X data while in_retry=1 has no effect.

Optional Feature:
DR_REQ_ARB_STATS_EN
- Defined: adds output stat_grant_cnt (NPORTS*16 bits), one 16-bit saturating counter per port, incremented on each grant to that port. Also adds stat_stall_cnt (16 bits, saturating), incremented each cycle with out_valid & out_retry. All counters reset to 0; they hold at 16'hFFFF.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
1. Single port: after reset, port 2 sends paddr 0x1000, out_retry=0 -> out_valid rises 1 cycle after the handshake, out_port=2, out_req.paddr=0x1000, in_retry[2] never asserts.
2. All 4 ports valid continuously, out_retry=0 -> out_port sequence 0,1,2,3,0,1,... with one grant per cycle and no gaps.
3. Ports 1 and 3 pending, out_retry=1 for 5 cycles -> out_req held stable, in_retry[1] and in_retry[3] = 1, no grant; after release the next grant goes to the other port (round-robin continues from last_grant).
4. Port 0 streams 8 requests l2id 0..7 back-to-back -> out_req.l2id 0..7 in order at 1 per cycle, in_retry[0] stays 0.
5. Reset asserted while 3 buffers and the output stage are full -> next cycle out_valid=0 and in_retry all 0; the first grant after reset goes to port 0.
6. With DR_REQ_ARB_STATS_EN: 70000 grants to port 1 plus 3 stall cycles -> stat_grant_cnt[1]=16'hFFFF (saturated), stat_stall_cnt=3.
